nrisc_run_ctrl: RTL and testbench
=================================

# nrisc_run_ctrl

Run/load sequencer for the nRisc single-cycle core. It sits between a host command port and the core. It streams a program into instruction memory, holds the core in reset while loading, and gates the core's state-update enable to implement RUN, STEP, STOP, breakpoint and Halt-stop. The core's PC, register bank, COND register and data-memory write all qualify on `core_en`.

## Interface
- `CNT_W`, 16: width of the executed-instruction counter.
- `CLK` in 1: sole clock; all state on rising edge.
- `RESET` in 1: asynchronous, active-high reset.
- `cmd_valid` in 1: host command beat valid.
- `cmd_ready` out 1: beat accepted when `cmd_valid && cmd_ready`.
- `cmd_op` in 2: 00 STOP, 01 RUN, 10 STEP, 11 LOAD.
- `cmd_data` in 8: LOAD length N (0 means 256), or a program byte while in LOAD.
- `halt_in` in 1: Halt decode from the core's control unit for the current instruction.
- `pc_in` in 8: current core PC.
- `brk_en` in 1: breakpoint enable.
- `brk_addr` in 8: breakpoint PC.
- `core_en` out 1: core advance enable; combinational.
- `core_rst` out 1: synchronous reset request to the core (PC, registers, COND).
- `imem_we` out 1: instruction-memory write strobe; combinational.
- `imem_addr` out 8: instruction-memory write address.
- `imem_wdata` out 8: instruction-memory write data (`cmd_data` passthrough).
- `state` out 3: 0 IDLE, 1 LOAD, 2 RUN, 3 STEP, 4 PAUSED, 5 HALTED.
- `brk_hit` out 1: sticky flag, set when a breakpoint stopped execution.
- `instr_count` out CNT_W: number of `core_en` cycles; saturating.

## Operation
- Internal registers:
  - `load_ptr[7:0]` and `load_left[8:0]`.
  - `skip_brk`: exempts the first enabled cycle after RUN/STEP so execution can leave a breakpoint.
  - `rst_pulse`.
- Enable and strobe logic:
  - `bp = brk_en && pc_in==brk_addr && !skip_brk`.
  - `core_en = (state==RUN || state==STEP) && !halt_in && !bp`.
  - `imem_we = state==LOAD && cmd_valid && cmd_op!=STOP`.
  - `imem_addr = load_ptr`.
- `core_rst = (state==LOAD) || rst_pulse`.
- `cmd_ready = (state != STEP)`.
- IDLE / PAUSED:
  - RUN → RUN, set `skip_brk`.
  - STEP → STEP, set `skip_brk`.
  - LOAD → LOAD: `load_left` = N, `load_ptr` = 0, `instr_count` = 0.
  - STOP: no effect.
  - Any accepted RUN/STEP/LOAD clears `brk_hit`.
- RUN, priority halt > breakpoint > STOP:
  - `halt_in` → HALTED.
  - `bp` → PAUSED and set `brk_hit`.
  - STOP accepted → PAUSED.
  - Other ops are accepted and ignored.
- STEP:
  - `halt_in` → HALTED.
  - Otherwise exactly one `core_en` cycle, then PAUSED.
  - The breakpoint is never checked in STEP, because `skip_brk` is always set on entry.
- HALTED:
  - Only LOAD is acted on (→ LOAD).
  - Other ops are accepted and ignored.
  - `core_en` stays 0.
- LOAD:
  - Each accepted non-STOP beat writes `cmd_data` to `load_ptr`, increments `load_ptr` (wraps 255→0) and decrements `load_left`.
  - The beat that brings `load_left` to 0 moves to IDLE and sets `rst_pulse` for one cycle.
  - STOP aborts to IDLE with no write; `rst_pulse` is also set.
- `skip_brk` clears after any cycle with `state` in {RUN, STEP}.
- `instr_count` increments on each `core_en` cycle and saturates at all-ones.

## Timing
- Async RESET values:
  - `state`=IDLE.
  - `rst_pulse`=1, so `core_rst` is high through RESET and for the first clock after release.
  - `brk_hit`=0, `instr_count`=0, `load_ptr`=0, `load_left`=0, `skip_brk`=0.
  - `core_en`=0, `imem_we`=0.
- A RESET mid-LOAD discards the partial load; bytes already written remain in memory.
- A command accepted in cycle t changes `state` at edge t+1.
- First `core_en` is high in cycle t+1 after a RUN/STEP accept.
- Halt instruction at cycle t in RUN:
  - `core_en`=0 in cycle t, so the PC does not pass the Halt.
  - `state`=HALTED from t+1.
- Breakpoint: `core_en`=0 in the same cycle `pc_in` matches; the PC stays at `brk_addr`.
- STOP accepted in RUN at cycle t: `core_en` is still high in t; PAUSED from t+1.
- LOAD of N bytes: N accepted beats, back-pressure free. The last write happens at cycle t; IDLE with `core_rst`=1 during t+1; `core_rst`=0 from t+2.
- N=0 loads 256 bytes, addresses 0..255.

## Test plan
- Release RESET → `core_rst`=1 for 1 cycle, then 0; `state`=0; `core_en`=0; `instr_count`=0.
- LOAD N=3, bytes 0xA1,0xB2,0xC3 → writes to addresses 0,1,2; then `state`=IDLE and a one-cycle `core_rst`. LOAD N=0 → 256 writes, with `imem_addr` wrapping from 255 to 0.
- RUN with `halt_in` asserted at `pc_in`=5 → exactly 5 `core_en` cycles, `instr_count`=5, `state`=HALTED. A subsequent RUN is ignored.
- `brk_en`=1, `brk_addr`=3, RUN → stop at PC 3 with `brk_hit`=1 and `state`=PAUSED. A following RUN advances past PC 3 and clears `brk_hit`.
- STEP three times from PAUSED → exactly one `core_en` cycle each; `cmd_ready`=0 during STEP; `instr_count` +3. STEP when `halt_in`=1 → HALTED with no `core_en`.
- STOP during LOAD after 2 of 4 bytes → IDLE, no further writes, `core_rst` pulse. RESET asserted mid-RUN → immediate IDLE with `core_en`=0.

Source files
------------

// File: rtl/nrisc_run_ctrl.sv
// nrisc_run_ctrl: run/load sequencer for the nRisc core.
// Streams a program into instruction memory and gates the core advance
// enable for RUN, STEP, STOP, breakpoint and Halt-stop.
module nrisc_run_ctrl #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [7:0]       cmd_data,
    input  logic             halt_in,
    input  logic [7:0]       pc_in,
    input  logic             brk_en,
    input  logic [7:0]       brk_addr,
    output logic             core_en,
    output logic             core_rst,
    output logic             imem_we,
    output logic [7:0]       imem_addr,
    output logic [7:0]       imem_wdata,
    output logic [2:0]       state,
    output logic             brk_hit,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_RUN    = 3'd2,
        S_STEP   = 3'd3,
        S_PAUSED = 3'd4,
        S_HALTED = 3'd5
    } state_t;

    localparam logic [1:0] OP_STOP = 2'b00;
    localparam logic [1:0] OP_RUN  = 2'b01;
    localparam logic [1:0] OP_STEP = 2'b10;
    localparam logic [1:0] OP_LOAD = 2'b11;

    state_t           state_q, state_d;
    logic [7:0]       load_ptr_q, load_ptr_d;
    logic [8:0]       load_left_q, load_left_d;
    logic             skip_brk_q, skip_brk_d;
    logic             rst_pulse_q, rst_pulse_d;
    logic             brk_hit_q, brk_hit_d;
    logic [CNT_W-1:0] instr_count_q, instr_count_d;

    logic cmd_acc;
    logic bp;
    logic executing;

    // Enable, strobe and handshake outputs derived from the current state.
    always_comb begin
        executing  = (state_q == S_RUN) || (state_q == S_STEP);
        bp         = brk_en && (pc_in == brk_addr) && !skip_brk_q;
        core_en    = executing && !halt_in && !bp;
        cmd_ready  = (state_q != S_STEP);
        cmd_acc    = cmd_valid && cmd_ready;
        imem_we    = (state_q == S_LOAD) && cmd_valid && (cmd_op != OP_STOP);
        imem_addr  = load_ptr_q;
        imem_wdata = cmd_data;
        core_rst   = (state_q == S_LOAD) || rst_pulse_q;
        state      = state_q;
        brk_hit    = brk_hit_q;
        instr_count = instr_count_q;
    end

    // Next-state and register update logic.
    always_comb begin
        state_d       = state_q;
        load_ptr_d    = load_ptr_q;
        load_left_d   = load_left_q;
        skip_brk_d    = executing ? 1'b0 : skip_brk_q;
        rst_pulse_d   = 1'b0;
        brk_hit_d     = brk_hit_q;
        instr_count_d = instr_count_q;

        if (core_en && (instr_count_q != '1))
            instr_count_d = instr_count_q + 1'b1;

        unique case (state_q)
            S_IDLE, S_PAUSED, S_HALTED: begin
                if (cmd_acc) begin
                    if (cmd_op == OP_LOAD) begin
                        state_d       = S_LOAD;
                        load_left_d   = (cmd_data == 8'd0) ? 9'd256 : {1'b0, cmd_data};
                        load_ptr_d    = '0;
                        instr_count_d = '0;
                        brk_hit_d     = 1'b0;
                    end else if (state_q != S_HALTED && cmd_op == OP_RUN) begin
                        state_d    = S_RUN;
                        skip_brk_d = 1'b1;
                        brk_hit_d  = 1'b0;
                    end else if (state_q != S_HALTED && cmd_op == OP_STEP) begin
                        state_d    = S_STEP;
                        skip_brk_d = 1'b1;
                        brk_hit_d  = 1'b0;
                    end
                end
            end
            S_RUN: begin
                if (halt_in) begin
                    state_d = S_HALTED;
                end else if (bp) begin
                    state_d   = S_PAUSED;
                    brk_hit_d = 1'b1;
                end else if (cmd_acc && cmd_op == OP_STOP) begin
                    state_d = S_PAUSED;
                end
            end
            S_STEP: begin
                state_d = halt_in ? S_HALTED : S_PAUSED;
            end
            S_LOAD: begin
                if (cmd_valid) begin
                    if (cmd_op == OP_STOP) begin
                        state_d     = S_IDLE;
                        rst_pulse_d = 1'b1;
                    end else begin
                        load_ptr_d  = load_ptr_q + 8'd1;
                        load_left_d = load_left_q - 9'd1;
                        if (load_left_q == 9'd1) begin
                            state_d     = S_IDLE;
                            rst_pulse_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset holds the core in reset one cycle past release.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q       <= S_IDLE;
            load_ptr_q    <= '0;
            load_left_q   <= '0;
            skip_brk_q    <= 1'b0;
            rst_pulse_q   <= 1'b1;
            brk_hit_q     <= 1'b0;
            instr_count_q <= '0;
        end else begin
            state_q       <= state_d;
            load_ptr_q    <= load_ptr_d;
            load_left_q   <= load_left_d;
            skip_brk_q    <= skip_brk_d;
            rst_pulse_q   <= rst_pulse_d;
            brk_hit_q     <= brk_hit_d;
            instr_count_q <= instr_count_d;
        end
    end

endmodule

// File: tb/tb_nrisc_run_ctrl.sv
// Directed testbench for nrisc_run_ctrl with a tiny behavioural core PC model.
module tb_nrisc_run_ctrl;

    logic        CLK;
    logic        RESET;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [7:0]  cmd_data;
    logic        halt_in;
    logic [7:0]  pc_in;
    logic        brk_en;
    logic [7:0]  brk_addr;
    logic        core_en;
    logic        core_rst;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [7:0]  imem_wdata;
    logic [2:0]  state;
    logic        brk_hit;
    logic [15:0] instr_count;

    logic [7:0]  pc;
    logic        halt_mode;
    logic [7:0]  halt_pc;

    int n_tests;
    int n_fail;

    nrisc_run_ctrl #(.CNT_W(16)) dut (
        .CLK(CLK), .RESET(RESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
        .halt_in(halt_in), .pc_in(pc_in), .brk_en(brk_en), .brk_addr(brk_addr),
        .core_en(core_en), .core_rst(core_rst),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .state(state), .brk_hit(brk_hit), .instr_count(instr_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Core PC model: synchronous reset on core_rst, advance on core_en.
    always @(posedge CLK) begin
        if (core_rst) pc <= 8'd0;
        else if (core_en) pc <= pc + 8'd1;
    end

    assign pc_in   = pc;
    assign halt_in = halt_mode && (pc == halt_pc);

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_load(input int n);
        cmd_valid = 1'b1; cmd_op = 2'b11; cmd_data = n[7:0];
        cyc();
        for (int i = 0; i < n; i++) begin
            cmd_op = 2'b01; cmd_data = 8'h00;
            cyc();
        end
        cmd_valid = 1'b0;
        cyc();
        cyc();
    endtask

    task automatic test_reset();
        RESET = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = 8'h00;
        brk_en = 1'b0; brk_addr = 8'h00; halt_mode = 1'b0; halt_pc = 8'h00;
        repeat (2) @(posedge CLK);
        #1;
        n_tests++; if (core_rst !== 1'b1) begin n_fail++; $display("FAIL rst_core_rst got %0b want 1", core_rst); end
        n_tests++; if (state !== 3'd0) begin n_fail++; $display("FAIL rst_state got %0d want 0", state); end
        n_tests++; if (core_en !== 1'b0) begin n_fail++; $display("FAIL rst_core_en got %0b want 0", core_en); end
        n_tests++; if (imem_we !== 1'b0) begin n_fail++; $display("FAIL rst_imem_we got %0b want 0", imem_we); end
        n_tests++; if (instr_count !== 16'd0) begin n_fail++; $display("FAIL rst_count got %0d want 0", instr_count); end
        RESET = 1'b0;
        #1;
        n_tests++; if (core_rst !== 1'b1) begin n_fail++; $display("FAIL rel_core_rst got %0b want 1", core_rst); end
        cyc();
        n_tests++; if (core_rst !== 1'b0) begin n_fail++; $display("FAIL rel2_core_rst got %0b want 0", core_rst); end
        n_tests++; if (state !== 3'd0) begin n_fail++; $display("FAIL rel2_state got %0d want 0", state); end
    endtask

    task automatic test_load3();
        logic [7:0] b [3];
        b[0] = 8'hA1; b[1] = 8'hB2; b[2] = 8'hC3;
        cmd_valid = 1'b1; cmd_op = 2'b11; cmd_data = 8'd3;
        #1;
        n_tests++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL l3_ready got %0b want 1", cmd_ready); end
        n_tests++; if (imem_we !== 1'b0) begin n_fail++; $display("FAIL l3_we_idle got %0b want 0", imem_we); end
        cyc();
        n_tests++; if (state !== 3'd1) begin n_fail++; $display("FAIL l3_state got %0d want 1", state); end
        n_tests++; if (core_rst !== 1'b1) begin n_fail++; $display("FAIL l3_core_rst got %0b want 1", core_rst); end
        for (int i = 0; i < 3; i++) begin
            cmd_op = 2'b01; cmd_data = b[i];
            #1;
            n_tests++; if (imem_we !== 1'b1 || imem_addr !== i[7:0] || imem_wdata !== b[i]) begin
                n_fail++; $display("FAIL l3_write%0d got we=%0b addr=%0d data=%h want we=1 addr=%0d data=%h", i, imem_we, imem_addr, imem_wdata, i, b[i]);
            end
            cyc();
        end
        cmd_valid = 1'b0;
        #1;
        n_tests++; if (state !== 3'd0) begin n_fail++; $display("FAIL l3_done_state got %0d want 0", state); end
        n_tests++; if (core_rst !== 1'b1) begin n_fail++; $display("FAIL l3_pulse got %0b want 1", core_rst); end
        cyc();
        n_tests++; if (core_rst !== 1'b0) begin n_fail++; $display("FAIL l3_pulse_end got %0b want 0", core_rst); end
    endtask

    task automatic test_load256();
        cmd_valid = 1'b1; cmd_op = 2'b11; cmd_data = 8'd0;
        cyc();
        for (int i = 0; i < 256; i++) begin
            logic [7:0] a;
            a = i[7:0];
            cmd_op = 2'b10; cmd_data = a ^ 8'h5A;
            #1;
            n_tests++; if (imem_we !== 1'b1 || imem_addr !== a) begin
                n_fail++; $display("FAIL l256_write got we=%0b addr=%0d want we=1 addr=%0d", imem_we, imem_addr, a);
            end
            if (i == 255) begin
                n_tests++; if (state !== 3'd1) begin n_fail++; $display("FAIL l256_last_state got %0d want 1", state); end
            end
            cyc();
        end
        cmd_valid = 1'b0;
        #1;
        n_tests++; if (state !== 3'd0) begin n_fail++; $display("FAIL l256_state got %0d want 0", state); end
        n_tests++; if (imem_addr !== 8'd0) begin n_fail++; $display("FAIL l256_wrap got %0d want 0", imem_addr); end
        cyc();
        cyc();
    endtask

    task automatic test_halt();
        int n;
        n = 0;
        halt_mode = 1'b1; halt_pc = 8'd5;
        cmd_valid = 1'b1; cmd_op = 2'b01;
        cyc();
        cmd_valid = 1'b0;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (state == 3'd5) break;
            if (core_en) n++;
            cyc();
        end
        n_tests++; if (n != 5) begin n_fail++; $display("FAIL halt_en_cycles got %0d want 5", n); end
        n_tests++; if (instr_count !== 16'd5) begin n_fail++; $display("FAIL halt_count got %0d want 5", instr_count); end
        n_tests++; if (state !== 3'd5) begin n_fail++; $display("FAIL halt_state got %0d want 5", state); end
        n_tests++; if (pc !== 8'd5) begin n_fail++; $display("FAIL halt_pc got %0d want 5", pc); end
        cyc();
        cmd_valid = 1'b1; cmd_op = 2'b01;
        #1;
        n_tests++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL halt_ready got %0b want 1", cmd_ready); end
        cyc();
        cmd_valid = 1'b0;
        cyc();
        n_tests++; if (state !== 3'd5 || core_en !== 1'b0) begin
            n_fail++; $display("FAIL halt_rerun got state=%0d en=%0b want state=5 en=0", state, core_en);
        end
        n_tests++; if (instr_count !== 16'd5) begin n_fail++; $display("FAIL halt_rerun_count got %0d want 5", instr_count); end
    endtask

    task automatic test_brk();
        int n;
        n = 0;
        halt_mode = 1'b0;
        do_load(1);
        brk_en = 1'b1; brk_addr = 8'd3;
        cmd_valid = 1'b1; cmd_op = 2'b01;
        cyc();
        cmd_valid = 1'b0;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (state == 3'd4) break;
            if (core_en) n++;
            cyc();
        end
        n_tests++; if (n != 3) begin n_fail++; $display("FAIL brk_en_cycles got %0d want 3", n); end
        n_tests++; if (pc !== 8'd3) begin n_fail++; $display("FAIL brk_pc got %0d want 3", pc); end
        n_tests++; if (brk_hit !== 1'b1) begin n_fail++; $display("FAIL brk_hit got %0b want 1", brk_hit); end
        n_tests++; if (state !== 3'd4) begin n_fail++; $display("FAIL brk_state got %0d want 4", state); end
        n_tests++; if (instr_count !== 16'd3) begin n_fail++; $display("FAIL brk_count got %0d want 3", instr_count); end
        cyc();
        cmd_valid = 1'b1; cmd_op = 2'b01;
        cyc();
        cmd_valid = 1'b0;
        #1;
        n_tests++; if (state !== 3'd2 || brk_hit !== 1'b0) begin
            n_fail++; $display("FAIL brk_resume got state=%0d hit=%0b want state=2 hit=0", state, brk_hit);
        end
        n_tests++; if (core_en !== 1'b1) begin n_fail++; $display("FAIL brk_leave got %0b want 1", core_en); end
        cyc();
        cmd_valid = 1'b1; cmd_op = 2'b00;
        #1;
        n_tests++; if (core_en !== 1'b1) begin n_fail++; $display("FAIL stop_en got %0b want 1", core_en); end
        cyc();
        cmd_valid = 1'b0;
        #1;
        n_tests++; if (state !== 3'd4 || pc !== 8'd5) begin
            n_fail++; $display("FAIL stop_state got state=%0d pc=%0d want state=4 pc=5", state, pc);
        end
        n_tests++; if (instr_count !== 16'd5) begin n_fail++; $display("FAIL stop_count got %0d want 5", instr_count); end
    endtask

    task automatic test_step();
        brk_addr = 8'd6;
        for (int s = 0; s < 3; s++) begin
            cmd_valid = 1'b1; cmd_op = 2'b10;
            cyc();
            cmd_valid = 1'b0;
            #1;
            n_tests++; if (state !== 3'd3 || cmd_ready !== 1'b0 || core_en !== 1'b1) begin
                n_fail++; $display("FAIL step%0d got state=%0d ready=%0b en=%0b want state=3 ready=0 en=1", s, state, cmd_ready, core_en);
            end
            cyc();
            n_tests++; if (state !== 3'd4 || core_en !== 1'b0) begin
                n_fail++; $display("FAIL step%0d_after got state=%0d en=%0b want state=4 en=0", s, state, core_en);
            end
        end
        n_tests++; if (instr_count !== 16'd8 || pc !== 8'd8) begin
            n_fail++; $display("FAIL step_total got count=%0d pc=%0d want count=8 pc=8", instr_count, pc);
        end
        halt_mode = 1'b1; halt_pc = 8'd8;
        cmd_valid = 1'b1; cmd_op = 2'b10;
        cyc();
        cmd_valid = 1'b0;
        #1;
        n_tests++; if (state !== 3'd3 || core_en !== 1'b0) begin
            n_fail++; $display("FAIL step_halt got state=%0d en=%0b want state=3 en=0", state, core_en);
        end
        cyc();
        n_tests++; if (state !== 3'd5 || instr_count !== 16'd8) begin
            n_fail++; $display("FAIL step_halted got state=%0d count=%0d want state=5 count=8", state, instr_count);
        end
    endtask

    task automatic test_load_abort();
        halt_mode = 1'b0; brk_en = 1'b0;
        cmd_valid = 1'b1; cmd_op = 2'b11; cmd_data = 8'd4;
        cyc();
        for (int i = 0; i < 2; i++) begin
            cmd_op = 2'b11; cmd_data = 8'h10 + i[7:0];
            #1;
            n_tests++; if (imem_we !== 1'b1 || imem_addr !== i[7:0]) begin
                n_fail++; $display("FAIL abort_write%0d got we=%0b addr=%0d want we=1 addr=%0d", i, imem_we, imem_addr, i);
            end
            cyc();
        end
        cmd_op = 2'b00;
        #1;
        n_tests++; if (imem_we !== 1'b0) begin n_fail++; $display("FAIL abort_we got %0b want 0", imem_we); end
        cyc();
        cmd_valid = 1'b0;
        #1;
        n_tests++; if (state !== 3'd0 || core_rst !== 1'b1) begin
            n_fail++; $display("FAIL abort_state got state=%0d rst=%0b want state=0 rst=1", state, core_rst);
        end
        cyc();
        n_tests++; if (core_rst !== 1'b0 || imem_we !== 1'b0) begin
            n_fail++; $display("FAIL abort_after got rst=%0b we=%0b want rst=0 we=0", core_rst, imem_we);
        end
    endtask

    task automatic test_reset_midrun();
        cmd_valid = 1'b1; cmd_op = 2'b01;
        cyc();
        cmd_valid = 1'b0;
        cyc();
        n_tests++; if (state !== 3'd2 || core_en !== 1'b1) begin
            n_fail++; $display("FAIL midrun_run got state=%0d en=%0b want state=2 en=1", state, core_en);
        end
        RESET = 1'b1;
        #1;
        n_tests++; if (state !== 3'd0 || core_en !== 1'b0 || core_rst !== 1'b1) begin
            n_fail++; $display("FAIL midrun_reset got state=%0d en=%0b rst=%0b want state=0 en=0 rst=1", state, core_en, core_rst);
        end
        n_tests++; if (instr_count !== 16'd0) begin n_fail++; $display("FAIL midrun_count got %0d want 0", instr_count); end
        cyc();
        RESET = 1'b0;
        cyc();
        cyc();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_load3();
        test_load256();
        test_halt();
        test_brk();
        test_step();
        test_load_abort();
        test_reset_midrun();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
